mix_columns_iter: RTL and testbench
===================================

Name: mix_columns_iter

Overview:
- Iterative AES MixColumns / InvMixColumns stage that sits directly downstream of the ShiftRow stage in the round datapath.
- Accepts a 128-bit state through a valid/ready handshake and transforms COLS_PER_CYCLE columns per clock.
- Presents the result through a valid/ready output handshake.
- Provides a bypass for the final AES round, where MixColumns is skipped.

Parameters:
- COLS_PER_CYCLE, 1, columns transformed per BUSY cycle; legal values 1, 2, 4; any other value is an elaboration error.

Ports:
- clk_i  input  1  clock; all logic is on the rising edge.
- rst_ni  input  1  synchronous, active-low reset.
- valid_i  input  1  input state valid.
- ready_o  output  1  block can accept an input this cycle.
- data_i  input  128  input state in column-major order; column c = data_i[127-32c -: 32]; row 0 is the MSB byte of each column.
- inv_i  input  1  0 = MixColumns, 1 = InvMixColumns; sampled on accept.
- bypass_i  input  1  1 = pass the state through unchanged (final round); sampled on accept.
- valid_o  output  1  output state valid.
- ready_i  input  1  downstream accepts the output.
- data_o  output  128  result, same byte layout as data_i.

Behaviour:
- Reset: synchronous and active-low. Reset is sampled on the clk_i rising edge while rst_ni=0.
  - State returns to IDLE; valid_o=0; data_o=0; the column counter and the captured inv/bypass flags clear to 0.
  - Reset overrides any in-flight operation: no partial result is ever presented.
- Acceptance: an input is accepted on a rising edge where valid_i && ready_o. On acceptance the block captures data_i, inv_i and bypass_i.
- ready_o = (state==IDLE) || (state==DONE && ready_i). This gives a combinational path from ready_i to ready_o and no combinational path from valid_i.
- FSM:
  - IDLE: on accept with bypass=0, go to BUSY with col=0. On accept with bypass=1, go to DONE with data_o = captured state.
  - BUSY: each cycle, transform columns col..col+COLS_PER_CYCLE-1 in place in the state register, then col += COLS_PER_CYCLE. When the last column is done, go to DONE.
  - DONE: hold valid_o=1 and hold data_o stable until valid_o && ready_i.
    - If handshake and a new accept occur in the same cycle, take the IDLE-accept transition directly (back-to-back).
    - If handshake occurs with no new accept, go to IDLE.
- Latency from accept edge to valid_o high:
  - 4/COLS_PER_CYCLE + 1 edges: 5, 3 or 2 for COLS_PER_CYCLE = 1, 2, 4.
  - Bypass: 1 edge.
- Throughput: one state per 4/COLS_PER_CYCLE + 1 cycles when ready_i is held high.
- Column arithmetic is in GF(2^8) with reduction polynomial 0x11B. xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1B : 8'h00).
  - Forward: r0=2a0^3a1^a2^a3, r1=a0^2a1^3a2^a3, r2=a0^a1^2a2^3a3, r3=3a0^a1^a2^2a3.
  - Inverse: uses coefficient matrix {0e,0b,0d,09}, circulant in the same pattern; 9, b, d and e are built from chained xtime.
- Columns are independent. The result must be bit-identical for every COLS_PER_CYCLE value.
- valid_i while busy: ignored (ready_o=0). The upstream stage holds data_i until accepted.
- inv_i and bypass_i changes after acceptance have no effect on the in-flight state.

Test Plan:
- Reset: hold rst_ni=0 for 2 edges with valid_i=1 → valid_o=0, ready_o=1, data_o=0. Then assert rst_ni=0 during BUSY → IDLE next edge and no valid_o.
- Forward FIPS-197 columns, COLS_PER_CYCLE=1: data_i = db135345_f20a225c_01010101_c6c6c6c6, inv_i=0 → data_o = 8e4da1bc_9fdc589d_01010101_c6c6c6c6, valid_o high exactly 5 edges after accept.
- Inverse: data_i = 8e4da1bc_9fdc589d_01010101_c6c6c6c6, inv_i=1 → data_o = db135345_f20a225c_01010101_c6c6c6c6. Repeat with COLS_PER_CYCLE=2 and 4: identical data, latency 3 and 2.
- Bypass: bypass_i=1, data_i = 00112233_44556677_8899aabb_ccddeeff → same value on data_o after 1 edge.
- Backpressure: ready_i=0 for 7 cycles in DONE → valid_o stays 1, data_o stable, ready_o=0. Then ready_i=1 with valid_i=1 → output handshake and new accept on the same edge, and the block goes straight to BUSY.
- Random: 1000 random states with random inv_i, bypass_i, valid_i and ready_i → matches the software model; MixColumns followed by InvMixColumns is the identity.

Source files
------------

// File: rtl/mix_columns_iter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// mix_columns_iter : iterative AES (Inv)MixColumns with final-round bypass
// Revision: 1.0
// ============================================================================
module mix_columns_iter #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [127:0] data_i,
    input  logic         inv_i,
    input  logic         bypass_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [127:0] data_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [2:0] C_STEP = 3'(COLS_PER_CYCLE);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
            $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // k[i][j] = i-th circulant coefficient times byte j; row r uses k[(j-r)&3][j]
    function automatic logic [31:0] mix_column(input logic [31:0] col, input logic inv);
        logic [7:0] a  [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] k  [4][4];
        logic [7:0] acc;
        logic [31:0] res;
        res = 32'h0;
        for (int j = 0; j < 4; j++) begin
            a[j]  = col[31-8*j -: 8];
            x2[j] = xtime(a[j]);
            x4[j] = xtime(x2[j]);
            x8[j] = xtime(x4[j]);
            k[0][j] = inv ? (x8[j] ^ x4[j] ^ x2[j]) : x2[j];
            k[1][j] = inv ? (x8[j] ^ x2[j] ^ a[j])  : (x2[j] ^ a[j]);
            k[2][j] = inv ? (x8[j] ^ x4[j] ^ a[j])  : a[j];
            k[3][j] = inv ? (x8[j] ^ a[j])          : a[j];
        end
        for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) begin
                acc = acc ^ k[(j - r) & 3][j];
            end
            res[31-8*r -: 8] = acc;
        end
        return res;
    endfunction

    logic [1:0]   r_state;
    logic [127:0] r_data;
    logic [2:0]   r_col;
    logic         r_inv;
    logic         r_bypass;
    logic [2:0]   w_col_next;
    logic [127:0] w_data_busy;
    logic         w_accept;

    assign w_col_next = r_col + C_STEP;
    assign ready_o    = (r_state == S_IDLE) || ((r_state == S_DONE) && ready_i);
    assign w_accept   = valid_i && ready_o;
    assign valid_o    = (r_state == S_DONE);
    assign data_o     = r_data;

    genvar c;
    generate
        for (c = 0; c < 4; c++) begin : g_col
            logic w_active;
            assign w_active = !r_bypass && (3'(c) >= r_col) && (3'(c) < w_col_next);
            assign w_data_busy[127-32*c -: 32] = w_active ?
                mix_column(r_data[127-32*c -: 32], r_inv) : r_data[127-32*c -: 32];
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state  <= S_IDLE;
            r_data   <= '0;
            r_col    <= '0;
            r_inv    <= 1'b0;
            r_bypass <= 1'b0;
        end else if (w_accept) begin
            // covers both IDLE accept and the back-to-back accept out of DONE
            r_data   <= data_i;
            r_inv    <= inv_i;
            r_bypass <= bypass_i;
            r_col    <= '0;
            r_state  <= bypass_i ? S_DONE : S_BUSY;
        end else begin
            case (r_state)
                S_IDLE: ;
                S_BUSY: begin
                    r_data <= w_data_busy;
                    r_col  <= w_col_next;
                    if (w_col_next == 3'd4) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (ready_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mix_columns_iter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_mix_columns_iter : checks three instances (1, 2, 4 columns per cycle)
// Revision: 1.0
// ============================================================================
module tb_mix_columns_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [2:0]   v_in, inv_in, byp_in, rdy_in, v_out, rdy_out;
    logic [127:0] din  [3];
    logic [127:0] dout [3];

    int n_vec = 0;
    int n_err = 0;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            mix_columns_iter #(.COLS_PER_CYCLE(g == 0 ? 1 : (g == 1 ? 2 : 4))) u_dut (
                .clk_i   (clk),
                .rst_ni  (rst_n),
                .valid_i (v_in[g]),
                .ready_o (rdy_out[g]),
                .data_i  (din[g]),
                .inv_i   (inv_in[g]),
                .bypass_i(byp_in[g]),
                .valid_o (v_out[g]),
                .ready_i (rdy_in[g]),
                .data_o  (dout[g])
            );
        end
    endgenerate

    typedef struct {
        logic [127:0] d;
        logic         inv;
        logic         byp;
        logic [127:0] exp;
    } vec_t;

    vec_t tbl [5];

    function automatic int cpc(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] d, input logic inv);
        logic [7:0]   coef [4];
        logic [127:0] res;
        logic [7:0]   acc;
        coef[0] = inv ? 8'h0E : 8'h02;
        coef[1] = inv ? 8'h0B : 8'h03;
        coef[2] = inv ? 8'h0D : 8'h01;
        coef[3] = inv ? 8'h09 : 8'h01;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    acc = acc ^ gmul(d[127-32*c-8*j -: 8], coef[(j - r + 4) % 4]);
                end
                res[127-32*c-8*r -: 8] = acc;
            end
        end
        return res;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // one transaction on instance k, checking latency and the result
    task automatic apply_vec(input int k, input logic [127:0] d, input logic inv,
                             input logic byp, input logic [127:0] exp);
        int lat;
        v_in[k] = 1'b1; din[k] = d; inv_in[k] = inv; byp_in[k] = byp; rdy_in[k] = 1'b1;
        #1;
        chk("ready_o before accept", 128'(rdy_out[k]), 128'(1));
        step();
        v_in[k] = 1'b0; din[k] = ~d; inv_in[k] = ~inv; byp_in[k] = ~byp;
        lat = 1;
        while (!v_out[k] && lat < 20) begin
            step();
            lat++;
        end
        chk("latency", 128'(lat), 128'(byp ? 1 : 4 / cpc(k) + 1));
        chk("data_o", dout[k], exp);
        step();
        chk("valid_o after handshake", 128'(v_out[k]), 128'(0));
    endtask

    task automatic backpressure(input int k);
        int lat;
        logic [127:0] y;
        y = model(tbl[0].d, 1'b0);
        v_in[k] = 1'b1; din[k] = tbl[0].d; inv_in[k] = 1'b0; byp_in[k] = 1'b0; rdy_in[k] = 1'b0;
        step();
        v_in[k] = 1'b0;
        lat = 1;
        while (!v_out[k] && lat < 20) begin
            step();
            lat++;
        end
        chk("bp valid_o", 128'(v_out[k]), 128'(1));
        for (int i = 0; i < 7; i++) begin
            step();
            chk("bp valid_o held", 128'(v_out[k]), 128'(1));
            chk("bp data_o stable", dout[k], y);
            chk("bp ready_o low", 128'(rdy_out[k]), 128'(0));
        end
        rdy_in[k] = 1'b1; v_in[k] = 1'b1; din[k] = y; inv_in[k] = 1'b1;
        #1;
        chk("bp ready_o follows ready_i", 128'(rdy_out[k]), 128'(1));
        step();
        v_in[k] = 1'b0;
        chk("b2b valid_o drops", 128'(v_out[k]), 128'(0));
        chk("b2b busy ready_o", 128'(rdy_out[k]), 128'(0));
        lat = 1;
        while (!v_out[k] && lat < 20) begin
            step();
            lat++;
        end
        chk("b2b latency", 128'(lat), 128'(4 / cpc(k) + 1));
        chk("b2b data_o", dout[k], tbl[0].d);
        step();
    endtask

    // random traffic with a scoreboard queue of expected outputs
    task automatic rand_run(input int k, input int n);
        logic [127:0] q [$];
        logic [127:0] e;
        int  acc_n;
        int  cyc;
        bit  hold;
        acc_n = 0; cyc = 0; hold = 1'b0;
        while ((acc_n < n || q.size() > 0) && cyc < 10000) begin
            if (!hold) begin
                v_in[k]   = (acc_n < n) ? 1'($urandom_range(0, 1)) : 1'b0;
                din[k]    = {$urandom, $urandom, $urandom, $urandom};
                inv_in[k] = 1'($urandom_range(0, 1));
                byp_in[k] = ($urandom_range(0, 7) == 0);
            end
            rdy_in[k] = ($urandom_range(0, 3) != 0);
            #1;
            if (v_out[k] && rdy_in[k]) begin
                if (q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL random unexpected output: got %h, expected none", dout[k]);
                end else begin
                    e = q.pop_front();
                    chk("random data_o", dout[k], e);
                end
            end
            if (v_in[k] && rdy_out[k]) begin
                q.push_back(byp_in[k] ? din[k] : model(din[k], inv_in[k]));
                acc_n++;
                hold = 1'b0;
            end else begin
                hold = v_in[k];
            end
            step();
            cyc++;
        end
        if (cyc >= 10000) begin
            n_vec++; n_err++;
            $display("FAIL random timeout: got %0d outstanding, expected 0", q.size());
        end
        v_in[k] = 1'b0; rdy_in[k] = 1'b1;
        step();
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] x, y;
        int seen;

        tbl[0] = '{128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, 1'b0,
                   128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6};
        tbl[1] = '{128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b1, 1'b0,
                   128'hdb135345_f20a225c_01010101_c6c6c6c6};
        tbl[2] = '{128'h00112233_44556677_8899aabb_ccddeeff, 1'b1, 1'b1,
                   128'h00112233_44556677_8899aabb_ccddeeff};
        tbl[3] = '{128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b0, 1'b0,
                   128'h046681e5_e0cb199a_48f8d37a_2806264c};
        tbl[4] = '{128'h0, 1'b1, 1'b0, 128'h0};

        // reset with valid_i asserted must not accept anything
        rst_n = 1'b0; v_in = 3'b111; rdy_in = 3'b000; inv_in = 3'b000; byp_in = 3'b000;
        for (int k = 0; k < 3; k++) din[k] = {$urandom, $urandom, $urandom, $urandom};
        step();
        step();
        for (int k = 0; k < 3; k++) begin
            chk("reset valid_o", 128'(v_out[k]), 128'(0));
            chk("reset ready_o", 128'(rdy_out[k]), 128'(1));
            chk("reset data_o", dout[k], 128'h0);
        end
        v_in = 3'b000;
        rst_n = 1'b1;
        step();

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 5; i++) begin
                apply_vec(k, tbl[i].d, tbl[i].inv, tbl[i].byp, tbl[i].exp);
            end
        end

        // reset while BUSY discards the in-flight state
        v_in[0] = 1'b1; din[0] = tbl[0].d; inv_in[0] = 1'b0; byp_in[0] = 1'b0; rdy_in[0] = 1'b1;
        step();
        v_in[0] = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        chk("busy reset valid_o", 128'(v_out[0]), 128'(0));
        chk("busy reset ready_o", 128'(rdy_out[0]), 128'(1));
        chk("busy reset data_o", dout[0], 128'h0);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (v_out[0]) seen++;
        end
        chk("no output after busy reset", 128'(seen), 128'(0));

        for (int k = 0; k < 3; k++) backpressure(k);

        // forward then inverse through the DUT returns the original state
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 3; i++) begin
                x = {$urandom, $urandom, $urandom, $urandom};
                y = model(x, 1'b0);
                apply_vec(k, x, 1'b0, 1'b0, y);
                apply_vec(k, y, 1'b1, 1'b0, x);
            end
        end

        rand_run(0, 334);
        rand_run(1, 333);
        rand_run(2, 333);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
